// File: rtl/cr_huf_comp_pkg.sv
// Shared types and helpers for the Huffman-compressor FIFO write-port arbiter.
package cr_huf_comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } huf_arb_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned huf_log2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/cr_huf_comp_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping at N_REQ.
module cr_huf_comp_rr_pick
    import cr_huf_comp_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = huf_log2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = i_ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!o_any && i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
            // Explicit wrap keeps the candidate legal when N_REQ is not a power of two.
            w_cand = (w_cand == ID_W'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
        end
    end

endmodule

// File: rtl/cr_huf_comp_fifo_wr_arb.sv
// Frame-locked round-robin arbiter for the Huffman-compressor FIFO write port.
// Build option: CR_HUF_COMP_FIFO_ARB_PRIO0_EN gives requester 0 strict priority.
module cr_huf_comp_fifo_wr_arb
    import cr_huf_comp_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 55,
    parameter int unsigned SLOT_W   = 9,
    parameter int unsigned MIN_FREE = 4,
    parameter int unsigned ID_W     = huf_log2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_eof,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [SLOT_W-1:0]      fifo_free_slots,
    output logic                   fifo_wen,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   grant_vld,
    output logic [ID_W-1:0]        grant_id
);

    localparam logic [SLOT_W-1:0] MIN_FREE_V = SLOT_W'(MIN_FREE);

    huf_arb_state_e  r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_rr_ptr;

    logic [N_REQ-1:0] w_pick_req;
    logic [ID_W-1:0]  w_rr_idx;
    logic             w_rr_any;
    logic [ID_W-1:0]  w_win_idx;
    logic             w_any_req;
    logic             w_ptr_upd;
    logic [ID_W-1:0]  w_next_ptr;
    logic             w_slot_ok;
    logic             w_admit;
    logic             w_eof_acc;
    logic [WIDTH-1:0] w_data_arr [N_REQ];

`ifdef CR_HUF_COMP_FIFO_ARB_PRIO0_EN
    // Requester 0 bypasses the rotation and never advances the pointer.
    assign w_pick_req = {req_valid[N_REQ-1:1], 1'b0};
    assign w_win_idx  = req_valid[0] ? '0 : w_rr_idx;
    assign w_any_req  = req_valid[0] | w_rr_any;
    assign w_ptr_upd  = (r_grant_id != '0);
`else
    assign w_pick_req = req_valid;
    assign w_win_idx  = w_rr_idx;
    assign w_any_req  = w_rr_any;
    assign w_ptr_upd  = 1'b1;
`endif

    cr_huf_comp_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    assign fifo_wdata = w_data_arr[r_grant_id];
    assign w_next_ptr = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign w_slot_ok  = (r_state == LOCK) && !clear && (fifo_free_slots != '0);
    assign fifo_wen   = w_slot_ok & req_valid[r_grant_id];
    assign w_eof_acc  = fifo_wen & req_eof[r_grant_id];
    assign w_admit    = (r_state == IDLE) && !clear && w_any_req &&
                        (fifo_free_slots >= MIN_FREE_V);
    assign grant_vld  = (r_state == LOCK);
    assign grant_id   = r_grant_id;

    always_comb begin
        req_ready = '0;
        if (w_slot_ok) begin
            req_ready[r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_admit) begin
                        r_state    <= LOCK;
                        r_grant_id <= w_win_idx;
                    end
                end
                LOCK: begin
                    if (w_eof_acc) begin
                        r_state <= IDLE;
                        if (w_ptr_upd) begin
                            r_rr_ptr <= w_next_ptr;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cr_huf_comp_fifo_wr_arb.sv
// Self-checking bench for cr_huf_comp_fifo_wr_arb: behavioural model plus directed pins.
module tb_cr_huf_comp_fifo_wr_arb;

    localparam int N    = 4;
    localparam int W    = 55;
    localparam int SW   = 9;
    localparam int MINF = 4;
`ifdef CR_HUF_COMP_FIFO_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_eof;
    logic [N-1:0]   req_ready;
    logic [SW-1:0]  fifo_free_slots;
    logic           fifo_wen;
    logic [W-1:0]   fifo_wdata;
    logic           grant_vld;
    logic [1:0]     grant_id;

    cr_huf_comp_fifo_wr_arb #(
        .N_REQ    (N),
        .WIDTH    (W),
        .SLOT_W   (SW),
        .MIN_FREE (MINF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .clear           (clear),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_eof         (req_eof),
        .req_ready       (req_ready),
        .fifo_free_slots (fifo_free_slots),
        .fifo_wen        (fifo_wen),
        .fifo_wdata      (fifo_wdata),
        .grant_vld       (grant_vld),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus knobs
    logic [N-1:0] en;
    int  free_v;
    bit  clr_v;
    int  bub_pct;
    int  fixed_len;
    bit  chk_en;
    int  cyc;

    // Producers: accepted-beat counter, position within frame, frame length
    int pseq  [N];
    int pbeat [N];
    int plen  [N];

    // Model: locked flag, owner, round-robin start
    int m_lock, m_own, m_rr;
    bit           e_ok;
    logic [N-1:0] e_ready;
    bit           e_wen;
    int           p_win;

    int wr_cyc [$];
    int wr_id  [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input int i, input int s);
        logic [W-1:0] v;
        v        = '0;
        v[54:51] = 4'(i);
        v[50:32] = 19'(s * 3 + 7);
        v[31:0]  = 32'(s) ^ (32'(i) * 32'h9E3779B9);
        return v;
    endfunction

    function automatic int newlen();
        return (fixed_len != 0) ? fixed_len : int'($urandom_range(5, 1));
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int rr);
        if (PRIO && v[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (rr + k) % N;
            if (!(PRIO && j == 0) && v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int cnt(input int id);
        int c;
        c = 0;
        foreach (wr_id[k]) if (wr_id[k] == id) c++;
        return c;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = en[i] && (int'($urandom_range(99, 0)) >= bub_pct);
            req_data[i*W +: W] = mk(i, pseq[i]);
            req_eof[i]        = (pbeat[i] == plen[i] - 1);
        end
        fifo_free_slots = SW'(free_v);
        clear           = clr_v;
    endtask

    task automatic cyc_begin();
        drive();
        #1;
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        clr_v  = 1'b0;
        en     = '0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        m_lock = 0;
        m_own  = 0;
        m_rr   = 0;
        for (int i = 0; i < N; i++) begin
            pbeat[i] = 0;
            plen[i]  = newlen();
        end
        wr_cyc.delete();
        wr_id.delete();
        chk_en = 1'b1;
    endtask

    task automatic drain(input int lim, input string nm);
        int k;
        for (k = 0; k < lim; k++) begin
            cyc_begin();
            cyc_end();
            if (m_lock == 0) break;
        end
        chk(nm, 64'(k < lim), 64'd1);
    endtask

    // Compare process: model outputs from the rules, check, then advance model at the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                e_ok    = (m_lock != 0) && !clear && (fifo_free_slots != 0);
                e_ready = e_ok ? (N'(1) << m_own) : '0;
                e_wen   = e_ok && req_valid[m_own];
                chk("req_ready", 64'(req_ready), 64'(e_ready));
                chk("fifo_wen", 64'(fifo_wen), 64'(e_wen));
                chk("grant_vld", 64'(grant_vld), 64'(m_lock != 0));
                chk("grant_id", 64'(grant_id), 64'(m_own));
                chk("fifo_wdata", 64'(fifo_wdata), 64'(mk(m_own, pseq[m_own])));
                if (clear) begin
                    m_lock = 0;
                    m_own  = 0;
                    m_rr   = 0;
                    for (int i = 0; i < N; i++) pbeat[i] = 0;
                end else if (m_lock == 0) begin
                    p_win = pick(req_valid, m_rr);
                    if (p_win >= 0 && fifo_free_slots >= SW'(MINF)) begin
                        m_lock = 1;
                        m_own  = p_win;
                    end
                end else if (e_wen) begin
                    wr_cyc.push_back(cyc);
                    wr_id.push_back(m_own);
                    if (req_eof[m_own]) begin
                        m_lock = 0;
                        if (!(PRIO && m_own == 0)) m_rr = (m_own + 1) % N;
                    end
                    pseq[m_own]++;
                    pbeat[m_own]++;
                    if (pbeat[m_own] == plen[m_own]) begin
                        pbeat[m_own] = 0;
                        plen[m_own]  = newlen();
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d0;
        int base, r;
        rst = 1'b1; clear = 1'b0; clr_v = 1'b0; en = '0; free_v = 100;
        bub_pct = 0; fixed_len = 3; chk_en = 1'b0; cyc = 0;
        m_lock = 0; m_own = 0; m_rr = 0;
        for (int i = 0; i < N; i++) begin
            pseq[i] = 0; pbeat[i] = 0; plen[i] = 3;
        end
        drive();
        #2;
        // Reset values before any clock edge
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_wen", 64'(fifo_wen), 64'd0);
        chk("rst_gvld", 64'(grant_vld), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_wdata", 64'(fifo_wdata), 64'(mk(0, 0)));

        // Basic round-robin, 3-beat frames, one bubble between frames
        fixed_len = 3;
        do_reset();
        en = '1; free_v = 100;
        base = cyc;
        repeat (20) begin cyc_begin(); cyc_end(); end
        chk("rr_nwrites", 64'(wr_id.size() >= 15), 64'd1);
        for (int k = 0; k < 15 && k < wr_id.size(); k++) begin
            chk("rr_cycle", 64'(wr_cyc[k] - base), 64'((k / 3) * 4 + (k % 3) + 1));
            chk("rr_id", 64'(wr_id[k]), 64'(PRIO ? 0 : (k / 3) % 4));
        end

        // Admission threshold
        fixed_len = 2;
        do_reset();
        en = 4'b0010; free_v = 3;
        repeat (3) begin
            cyc_begin(); chk("adm_hold", 64'(grant_vld), 64'd0); cyc_end();
        end
        free_v = 4;
        cyc_begin(); chk("adm_edge", 64'(grant_vld), 64'd0); cyc_end();
        cyc_begin();
        chk("adm_gvld", 64'(grant_vld), 64'd1);
        chk("adm_gid", 64'(grant_id), 64'd1);
        cyc_end();

        // Mid-frame backpressure
        fixed_len = 5;
        do_reset();
        en = 4'b0100; free_v = 100;
        repeat (2) begin cyc_begin(); cyc_end(); end
        free_v = 0;
        repeat (5) begin
            cyc_begin();
            chk("bp_ready", 64'(req_ready[2]), 64'd0);
            chk("bp_wen", 64'(fifo_wen), 64'd0);
            cyc_end();
        end
        free_v = 100;
        drain(20, "bp_drain");
        chk("bp_count", 64'(cnt(2)), 64'd5);

        // Bubbles within a frame, then a single-beat frame
        fixed_len = 2;
        do_reset();
        en = 4'b1000;
        repeat (2) begin cyc_begin(); cyc_end(); end
        en = '0;
        repeat (2) begin
            cyc_begin();
            chk("bub_gvld", 64'(grant_vld), 64'd1);
            chk("bub_gid", 64'(grant_id), 64'd3);
            chk("bub_wen", 64'(fifo_wen), 64'd0);
            cyc_end();
        end
        en = 4'b1000;
        drain(10, "bub_drain");
        chk("bub_count", 64'(cnt(3)), 64'd2);
        fixed_len = 1; plen[0] = 1; en = 4'b0001;
        drain(10, "single_drain");
        chk("single_count", 64'(cnt(0)), 64'd1);

        // Clear on beat 2 of 5
        fixed_len = 5;
        do_reset();
        en = 4'b0010;
        repeat (2) begin cyc_begin(); cyc_end(); end
        clr_v = 1'b1;
        cyc_begin();
        chk("clr_wen", 64'(fifo_wen), 64'd0);
        chk("clr_ready", 64'(req_ready), 64'd0);
        cyc_end();
        clr_v = 1'b0; en = '1;
        cyc_begin(); chk("clr_idle", 64'(grant_vld), 64'd0); cyc_end();
        cyc_begin();
        chk("clr_next_gvld", 64'(grant_vld), 64'd1);
        chk("clr_next_gid", 64'(grant_id), 64'd0);
        cyc_end();

        // Asynchronous reset mid-frame
        do_reset();
        en = 4'b0100;
        repeat (3) begin cyc_begin(); cyc_end(); end
        chk("arst_pre_gvld", 64'(grant_vld), 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        d0 = req_data[0 +: W];
        chk("arst_ready", 64'(req_ready), 64'd0);
        chk("arst_wen", 64'(fifo_wen), 64'd0);
        chk("arst_gvld", 64'(grant_vld), 64'd0);
        chk("arst_gid", 64'(grant_id), 64'd0);
        chk("arst_wdata", 64'(fifo_wdata), 64'(d0));

        // Requesters 0 and 2 continuously valid
        fixed_len = 2;
        do_reset();
        en = 4'b0101;
        repeat (16) begin cyc_begin(); cyc_end(); end
        chk("prio_nwrites", 64'(wr_id.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < wr_id.size(); k++) begin
            chk("prio_id", 64'(wr_id[k]), 64'(PRIO ? 0 : (((k / 2) % 2) != 0 ? 2 : 0)));
        end

        // Randomized traffic against the model
        fixed_len = 0;
        do_reset();
        bub_pct = 25;
        en = N'($urandom);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15, 0) == 0) en = N'($urandom);
            r = int'($urandom_range(9, 0));
            free_v = (r == 0) ? 0 : (r < 4) ? int'($urandom_range(5, 1)) : 100;
            clr_v = ($urandom_range(99, 0) == 0);
            cyc_begin();
            cyc_end();
        end
        clr_v = 1'b0;
        chk("rand_progress", 64'(wr_id.size() > 100), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
